// File: rtl/lcd_write_sequencer.sv
// HD44780 byte write engine: {RS,data} words are queued in a small FIFO and replayed on the LCD pins
// with setup / enable-pulse / hold / execution-wait timing. Define LCD_INIT_SEQ_EN for the power-on init sequence.
module lcd_write_sequencer #(
  parameter int SETUP_CYC      = 4,
  parameter int EN_CYC         = 12,
  parameter int HOLD_CYC       = 2,
  parameter int SHORT_WAIT_CYC = 2000,
  parameter int LONG_WAIT_CYC  = 80000,
  parameter int POWERUP_CYC    = 750000,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  input  logic       in_rs,
  output logic       busy,
  output logic [7:0] lcd_data,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_en
);

  localparam int CNT_MAX = (LONG_WAIT_CYC > POWERUP_CYC) ? LONG_WAIT_CYC : POWERUP_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int PTR_W   = $clog2(FIFO_DEPTH);

  typedef logic [CNT_W-1:0] cnt_t;
  typedef logic [PTR_W:0]   fcnt_t;

  // Counter load values are "cycles - 1": a phase ends on the edge that sees zero.
  localparam cnt_t  SETUP_LD = cnt_t'(SETUP_CYC - 1);
  localparam cnt_t  EN_LD    = cnt_t'(EN_CYC - 1);
  localparam cnt_t  HOLD_LD  = cnt_t'(HOLD_CYC - 1);
  localparam cnt_t  SHORT_LD = cnt_t'(SHORT_WAIT_CYC - 1);
  localparam cnt_t  LONG_LD  = cnt_t'(LONG_WAIT_CYC - 1);
  localparam fcnt_t FULL_CNT = fcnt_t'(FIFO_DEPTH);

`ifdef LCD_INIT_SEQ_EN
  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_PULSE, S_HOLD, S_WAIT, S_PWRUP, S_INIT} state_e;
  localparam state_e RST_STATE = S_PWRUP;
  localparam cnt_t   RST_CNT   = cnt_t'(POWERUP_CYC - 1);

  function automatic logic [7:0] init_cmd(input logic [2:0] idx);
    case (idx)
      3'd3:    return 8'h0C;
      3'd4:    return 8'h01;
      3'd5:    return 8'h06;
      default: return 8'h38;
    endcase
  endfunction

  logic       init_active_q, init_active_d;
  logic [2:0] init_idx_q, init_idx_d;
`else
  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_PULSE, S_HOLD, S_WAIT} state_e;
  localparam state_e RST_STATE = S_IDLE;
  localparam cnt_t   RST_CNT   = '0;
`endif

  state_e           state_q, state_d;
  cnt_t             cnt_q, cnt_d;
  logic [7:0]       lcd_data_q, lcd_data_d;
  logic             lcd_rs_q, lcd_rs_d;
  logic             lcd_en_q, lcd_en_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  fcnt_t            count_q, count_d;
  logic [8:0]       mem_q [FIFO_DEPTH];
  logic [8:0]       head;
  logic             fifo_empty, push, pop, launch, cnt_zero, long_wait;

  // ---------------- FIFO ----------------
  assign fifo_empty = (count_q == '0);
  assign in_ready   = (count_q != FULL_CNT);
  assign push       = in_valid && in_ready;
  assign head       = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q + PTR_W'(push);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    count_d  = count_q + fcnt_t'(push) - fcnt_t'(pop);
  end

  // NOTE: the storage array has no reset; count_q and the pointers alone decide which entries are valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {in_rs, in_data};
  end

  // ---------------- Sequencer ----------------
  assign cnt_zero  = (cnt_q == '0);
  // Clear display / return home (0x01..0x03) need the long execution time.
  assign long_wait = !lcd_rs_q && (lcd_data_q[7:2] == 6'd0) && (lcd_data_q[1:0] != 2'd0);

  always_comb begin
    // NOTE: every _d signal is given its hold value first, so no branch can leave one unassigned (no latches).
    state_d    = state_q;
    cnt_d      = cnt_zero ? cnt_q : cnt_q - cnt_t'(1);
    lcd_data_d = lcd_data_q;
    lcd_rs_d   = lcd_rs_q;
    lcd_en_d   = lcd_en_q;
    pop        = 1'b0;
    launch     = 1'b0;
`ifdef LCD_INIT_SEQ_EN
    init_active_d = init_active_q;
    init_idx_d    = init_idx_q;
`endif
    unique case (state_q)
      S_IDLE:  launch = 1'b1;
      S_SETUP: if (cnt_zero) begin
        state_d  = S_PULSE;
        cnt_d    = EN_LD;
        lcd_en_d = 1'b1;
      end
      S_PULSE: if (cnt_zero) begin
        state_d  = S_HOLD;
        cnt_d    = HOLD_LD;
        lcd_en_d = 1'b0;
      end
      S_HOLD: if (cnt_zero) begin
        state_d = S_WAIT;
        cnt_d   = long_wait ? LONG_LD : SHORT_LD;
      end
      S_WAIT: if (cnt_zero) begin
        state_d = S_IDLE;
`ifdef LCD_INIT_SEQ_EN
        if (init_active_q && (init_idx_q != 3'd6)) begin
          state_d = S_INIT;
        end else begin
          init_active_d = 1'b0;
          launch        = 1'b1;
        end
`else
        launch = 1'b1;
`endif
      end
`ifdef LCD_INIT_SEQ_EN
      S_PWRUP: if (cnt_zero) state_d = S_INIT;
      S_INIT: begin
        lcd_data_d = init_cmd(init_idx_q);
        lcd_rs_d   = 1'b0;
        init_idx_d = init_idx_q + 3'd1;
        state_d    = S_SETUP;
        cnt_d      = SETUP_LD;
      end
`endif
      default: state_d = S_IDLE;
    endcase

    // Shared by IDLE and the end of WAIT so back-to-back words start with no idle cycle.
    if (launch && !fifo_empty) begin
      pop        = 1'b1;
      lcd_data_d = head[7:0];
      lcd_rs_d   = head[8];
      state_d    = S_SETUP;
      cnt_d      = SETUP_LD;
    end
  end

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= RST_STATE;
      cnt_q      <= RST_CNT;
      lcd_data_q <= 8'h00;
      lcd_rs_q   <= 1'b0;
      lcd_en_q   <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
`ifdef LCD_INIT_SEQ_EN
      init_active_q <= 1'b1;
      init_idx_q    <= 3'd0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      lcd_data_q <= lcd_data_d;
      lcd_rs_q   <= lcd_rs_d;
      lcd_en_q   <= lcd_en_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
`ifdef LCD_INIT_SEQ_EN
      init_active_q <= init_active_d;
      init_idx_q    <= init_idx_d;
`endif
    end
  end

`ifdef LCD_INIT_SEQ_EN
  assign busy = !fifo_empty || (state_q != S_IDLE) || init_active_q;
`else
  assign busy = !fifo_empty || (state_q != S_IDLE);
`endif

  assign lcd_data = lcd_data_q;
  assign lcd_rs   = lcd_rs_q;
  assign lcd_en   = lcd_en_q;
  assign lcd_rw   = 1'b0;

endmodule

// File: tb/tb_lcd_write_sequencer.sv
// Self-checking bench for lcd_write_sequencer: monitors record accepted words and EN strobes,
// and a timeline model built from the word-level timing rules predicts every strobe.
module tb_lcd_write_sequencer;

  localparam int SETUP_CYC      = 4;
  localparam int EN_CYC         = 12;
  localparam int HOLD_CYC       = 2;
  localparam int SHORT_WAIT_CYC = 20;
  localparam int LONG_WAIT_CYC  = 80;
  localparam int POWERUP_CYC    = 50;
  localparam int FIFO_DEPTH     = 4;
  localparam int OCC_SHORT      = SETUP_CYC + EN_CYC + HOLD_CYC + SHORT_WAIT_CYC;
  localparam int OCC_LONG       = SETUP_CYC + EN_CYC + HOLD_CYC + LONG_WAIT_CYC;
`ifdef LCD_INIT_SEQ_EN
  localparam logic INIT_EN = 1'b1;
`else
  localparam logic INIT_EN = 1'b0;
`endif

  logic       clk      = 1'b0;
  logic       reset_n  = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data  = 8'h00;
  logic       in_rs    = 1'b0;
  logic       in_ready, busy, lcd_rs, lcd_rw, lcd_en;
  logic [7:0] lcd_data;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct { int at; logic rs; logic [7:0] data; } acc_t;
  typedef struct { int rise; int fall; logic rs; logic [7:0] data; } strobe_t;

  acc_t    acc_q[$];
  strobe_t obs_q[$];
  strobe_t cur;
  acc_t    acc_tmp;
  logic    prev_en   = 1'b0;
  logic    prev_busy = 1'b0;
  int      busy_fall = -1;
  int      rel_edge  = 0;
  int      exp_start[$];
  int      exp_rise[$];
  int      exp_fall[$];
  int      exp_finish;

  lcd_write_sequencer #(
    .SETUP_CYC(SETUP_CYC), .EN_CYC(EN_CYC), .HOLD_CYC(HOLD_CYC),
    .SHORT_WAIT_CYC(SHORT_WAIT_CYC), .LONG_WAIT_CYC(LONG_WAIT_CYC),
    .POWERUP_CYC(POWERUP_CYC), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_rs(in_rs), .busy(busy), .lcd_data(lcd_data),
    .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_en(lcd_en)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Edge index k means "the k-th rising edge"; at a falling edge, cyc is the index of the last rising edge.
  always @(negedge clk) begin
    if (reset_n && in_valid && in_ready) begin
      acc_tmp.at   = cyc + 1;
      acc_tmp.rs   = in_rs;
      acc_tmp.data = in_data;
      acc_q.push_back(acc_tmp);
    end
    if (lcd_en && !prev_en) begin
      cur.rise = cyc;
      cur.rs   = lcd_rs;
      cur.data = lcd_data;
    end
    if (!lcd_en && prev_en) begin
      cur.fall = cyc;
      obs_q.push_back(cur);
    end
    if (!busy && prev_busy) busy_fall = cyc;
    prev_en   = lcd_en;
    prev_busy = busy;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  function automatic int wait_len(input logic rs, input logic [7:0] d);
    return (!rs && d >= 8'd1 && d <= 8'd3) ? LONG_WAIT_CYC : SHORT_WAIT_CYC;
  endfunction

  // Timeline model: a word starts one cycle after it is accepted, or when the previous word's wait ends.
  task automatic run_model();
    int fin = 0;
    int st;
    exp_start.delete(); exp_rise.delete(); exp_fall.delete();
    foreach (acc_q[i]) begin
      st = (acc_q[i].at + 1 > fin) ? acc_q[i].at + 1 : fin;
      exp_start.push_back(st);
      exp_rise.push_back(st + SETUP_CYC);
      exp_fall.push_back(st + SETUP_CYC + EN_CYC);
      fin = st + SETUP_CYC + EN_CYC + HOLD_CYC + wait_len(acc_q[i].rs, acc_q[i].data);
    end
    exp_finish = fin;
  endtask

  task automatic score_strobes(input string tag);
    run_model();
    checks++;
    if (obs_q.size() != acc_q.size()) begin
      errors++;
      $display("FAIL %s strobe_count got %0d want %0d", tag, obs_q.size(), acc_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < acc_q.size(); i++) begin
      checks++;
      if (obs_q[i].rs !== acc_q[i].rs || obs_q[i].data !== acc_q[i].data) begin
        errors++;
        $display("FAIL %s word%0d got rs=%0b data=%02h want rs=%0b data=%02h", tag, i,
                 obs_q[i].rs, obs_q[i].data, acc_q[i].rs, acc_q[i].data);
      end
      checks++;
      if (obs_q[i].rise != exp_rise[i]) begin
        errors++;
        $display("FAIL %s en_rise%0d got %0d want %0d", tag, i, obs_q[i].rise, exp_rise[i]);
      end
      checks++;
      if (obs_q[i].fall != exp_fall[i]) begin
        errors++;
        $display("FAIL %s en_fall%0d got %0d want %0d", tag, i, obs_q[i].fall, exp_fall[i]);
      end
    end
    checks++;
    if (busy_fall != exp_finish) begin
      errors++;
      $display("FAIL %s busy_fall got %0d want %0d", tag, busy_fall, exp_finish);
    end
  endtask

  task automatic clear_logs();
    acc_q.delete();
    obs_q.delete();
    busy_fall = -1;
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    @(negedge clk);
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    reset_n  = 1'b1;
    rel_edge = cyc;
    clear_logs();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic rs, input logic [7:0] d);
    int n = 0;
    in_valid = 1'b1;
    in_rs    = rs;
    in_data  = d;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 3000);
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout got in_ready=0 want 1 within 3000 cycles");
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      in_valid = 1'b0;
    end
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy && n < 5000);
    checks++;
    if (busy) begin
      errors++;
      $display("FAIL %s idle_timeout got busy=1 want 0 within 5000 cycles", tag);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    in_valid = 1'b0;
    @(negedge clk);
    reset_n = 1'b0;
    for (int phase = 0; phase < 2; phase++) begin
      #1;
      checks++;
      if (lcd_en !== 1'b0)   begin errors++; $display("FAIL reset%0d lcd_en got %b want 0", phase, lcd_en); end
      checks++;
      if (lcd_rs !== 1'b0)   begin errors++; $display("FAIL reset%0d lcd_rs got %b want 0", phase, lcd_rs); end
      checks++;
      if (lcd_rw !== 1'b0)   begin errors++; $display("FAIL reset%0d lcd_rw got %b want 0", phase, lcd_rw); end
      checks++;
      if (lcd_data !== 8'h00) begin errors++; $display("FAIL reset%0d lcd_data got %02h want 00", phase, lcd_data); end
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL reset%0d in_ready got %b want 1", phase, in_ready); end
      checks++;
      if (busy !== INIT_EN)  begin errors++; $display("FAIL reset%0d busy got %b want %b", phase, busy, INIT_EN); end
      if (phase == 0) begin
        repeat (2) @(negedge clk);
        reset_n  = 1'b1;
        rel_edge = cyc;
        clear_logs();
        repeat (3) @(negedge clk);
      end
    end
    @(posedge clk);
    #1;
  endtask

`ifndef LCD_INIT_SEQ_EN
  task automatic test_single();
    do_reset();
    send(1'b1, 8'h41);
    @(posedge clk);
    #1;
    checks++;
    if (lcd_data !== 8'h41 || lcd_rs !== 1'b1) begin
      errors++;
      $display("FAIL single_load got rs=%b data=%02h want rs=1 data=41", lcd_rs, lcd_data);
    end
    checks++;
    if (lcd_en !== 1'b0) begin errors++; $display("FAIL single_setup_en got %b want 0", lcd_en); end
    wait_idle("single");
    score_strobes("single");
    checks++;
    if (acc_q.size() == 1 && busy_fall != acc_q[0].at + 1 + OCC_SHORT) begin
      errors++;
      $display("FAIL single_busy_fall got %0d want %0d", busy_fall, acc_q[0].at + 1 + OCC_SHORT);
    end
  endtask

  task automatic test_clear_gap();
    logic [7:0] cmd;
    int         want;
    for (int k = 0; k < 2; k++) begin
      cmd  = (k == 0) ? 8'h01 : 8'h38;
      want = (k == 0) ? OCC_LONG : OCC_SHORT;
      do_reset();
      send(1'b0, cmd);
      send(1'b1, 8'h42);
      wait_idle("clear_gap");
      score_strobes("clear_gap");
      checks++;
      if (obs_q.size() != 2 || obs_q[1].rise - obs_q[0].rise != want) begin
        errors++;
        $display("FAIL clear_gap_%02h got %0d want %0d", cmd,
                 (obs_q.size() == 2) ? obs_q[1].rise - obs_q[0].rise : -1, want);
      end
    end
  endtask

  task automatic test_fifo_full();
    int acc = 0;
    int n   = 0;
    do_reset();
    in_valid = 1'b1;
    in_rs    = 1'b1;
    in_data  = 8'h61;
    for (int it = 0; it < 20 && in_valid; it++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        #1;
        acc++;
        if (acc == 6) in_valid = 1'b0;
        else          in_data  = 8'(8'h61 + acc);
      end else begin
        in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    checks++;
    if (acc != FIFO_DEPTH + 1) begin
      errors++;
      $display("FAIL fifo_accepts got %0d want %0d", acc, FIFO_DEPTH + 1);
    end
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 200);
    run_model();
    checks++;
    if (exp_start.size() < 2 || !in_ready || cyc != exp_start[1]) begin
      errors++;
      $display("FAIL fifo_ready_return got %0d want %0d", cyc,
               (exp_start.size() > 1) ? exp_start[1] : -1);
    end
    wait_idle("fifo_full");
    score_strobes("fifo_full");
  endtask

  task automatic test_reset_mid();
    int n = 0;
    do_reset();
    send(1'b1, 8'h55);
    send(1'b1, 8'h56);
    while (!lcd_en && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!lcd_en) begin errors++; $display("FAIL rst_mid_en_timeout got lcd_en=0 want 1"); end
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (lcd_en !== 1'b0) begin errors++; $display("FAIL rst_mid_async_en got %b want 0", lcd_en); end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    clear_logs();
    @(negedge clk);
    checks++;
    if (lcd_data !== 8'h00 || lcd_rs !== 1'b0 || lcd_en !== 1'b0 || lcd_rw !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_outputs got data=%02h rs=%b en=%b rw=%b want 00/0/0/0", lcd_data, lcd_rs, lcd_en, lcd_rw);
    end
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_fifo got in_ready=%b busy=%b want 1/0", in_ready, busy);
    end
    repeat (150) @(negedge clk);
    checks++;
    if (obs_q.size() != 0) begin
      errors++;
      $display("FAIL rst_mid_discard got %0d strobes want 0", obs_q.size());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_random();
    int         gap;
    int         sel;
    logic       rs;
    logic [7:0] d;
    do_reset();
    for (int i = 0; i < 14; i++) begin
      gap = $urandom_range(0, 45);
      sel = $urandom_range(0, 2);
      if (sel == 0) begin
        rs = 1'b0;
        d  = 8'($urandom_range(0, 5));
      end else begin
        rs = 1'($urandom_range(0, 1));
        d  = 8'($urandom);
      end
      if (gap > 0) begin
        repeat (gap) @(posedge clk);
        #1;
      end
      send(rs, d);
    end
    wait_idle("random");
    score_strobes("random");
  endtask
`else
  task automatic test_init();
    logic [7:0] seq [7];
    seq = '{8'h38, 8'h38, 8'h38, 8'h0C, 8'h01, 8'h06, 8'h5A};
    do_reset();
    send(1'b1, 8'h5A);
    wait_idle("init");
    checks++;
    if (obs_q.size() != 7) begin
      errors++;
      $display("FAIL init_strobe_count got %0d want 7", obs_q.size());
    end
    checks++;
    if (obs_q.size() > 0 && obs_q[0].rise < rel_edge + POWERUP_CYC + SETUP_CYC) begin
      errors++;
      $display("FAIL init_powerup got first_rise=%0d want >=%0d", obs_q[0].rise, rel_edge + POWERUP_CYC + SETUP_CYC);
    end
    for (int i = 0; i < 7 && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i].data !== seq[i] || obs_q[i].rs !== (i == 6)) begin
        errors++;
        $display("FAIL init_word%0d got rs=%b data=%02h want rs=%0d data=%02h", i, obs_q[i].rs, obs_q[i].data, (i == 6), seq[i]);
      end
      checks++;
      if (obs_q[i].fall - obs_q[i].rise != EN_CYC) begin
        errors++;
        $display("FAIL init_width%0d got %0d want %0d", i, obs_q[i].fall - obs_q[i].rise, EN_CYC);
      end
      if (i > 0) begin
        checks++;
        if (obs_q[i].rise - obs_q[i-1].rise < ((i == 5) ? OCC_LONG : OCC_SHORT)) begin
          errors++;
          $display("FAIL init_gap%0d got %0d want >=%0d", i, obs_q[i].rise - obs_q[i-1].rise,
                   (i == 5) ? OCC_LONG : OCC_SHORT);
        end
      end
    end
  endtask
`endif

  initial begin
    test_reset();
`ifdef LCD_INIT_SEQ_EN
    test_init();
`else
    test_single();
    test_clear_gap();
    test_fifo_full();
    test_reset_mid();
    test_random();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lcd_write_sequencer.md
# lcd_write_sequencer

Byte-level write engine for the HD44780-compatible character LCD driven by the Nios system's LCD conduit (8-bit data, RS, RW, EN). It accepts {RS, data} words from the processor-side interface through a valid/ready handshake, buffers them in a small FIFO, and replays each one onto the LCD pins with the required setup, enable-pulse, hold and execution-wait timing. An optional power-on initialisation sequence runs before any queued word.

## Interface
- `SETUP_CYC`, 4: cycles from data/RS valid to EN rise.
- `EN_CYC`, 12: EN high width in cycles.
- `HOLD_CYC`, 2: cycles data/RS held after EN fall.
- `SHORT_WAIT_CYC`, 2000: execution wait after a normal command or data write.
- `LONG_WAIT_CYC`, 80000: execution wait after clear/home commands.
- `POWERUP_CYC`, 750000: power-on delay before the init sequence. Used only with init compiled in.
- `FIFO_DEPTH`, 4: entries; power of two, at least 2.

Ports:
- `clk`, in, 1: single clock.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `in_valid`, in, 1: word offered.
- `in_ready`, out, 1: FIFO can accept a word.
- `in_data`, in, 8: LCD byte.
- `in_rs`, in, 1: 0 = command, 1 = data.
- `busy`, out, 1: FIFO non-empty, or FSM not IDLE, or init active.
- `lcd_data`, out, 8: LCD DB7..DB0.
- `lcd_rs`, out, 1: LCD RS.
- `lcd_rw`, out, 1: tied 0; write-only.
- `lcd_en`, out, 1: LCD E strobe.

## Operation
- Handshake: a word is pushed on any rising edge where `in_valid && in_ready`. `in_ready` equals `!full` and is derived from the registered count. A push is refused while full, even on a cycle where a pop occurs.
- FSM states: IDLE, SETUP, PULSE, HOLD, WAIT. With init compiled in, the states also include PWRUP and INIT.
- IDLE to SETUP: taken when the FIFO is non-empty. The head word is popped and loaded into `lcd_data`/`lcd_rs`.
- SETUP to PULSE: after `SETUP_CYC` cycles. `lcd_en` is 1 throughout PULSE.
- PULSE to HOLD: after `EN_CYC` cycles. `lcd_en` returns to 0.
- HOLD to WAIT: after `HOLD_CYC` cycles.
- WAIT to IDLE (or directly to SETUP if the FIFO is non-empty): after the wait count.
- Wait selection: the long wait (`LONG_WAIT_CYC`) applies when `rs=0` and `data[7:2]==0` and `data!=0` (0x01, 0x02, 0x03). All other words use `SHORT_WAIT_CYC`.
- Outputs are registered. `lcd_data`/`lcd_rs` keep the last word's value in IDLE.
- Counter: a single down-counter wide enough for max(`LONG_WAIT_CYC`, `POWERUP_CYC`).

## Timing
- Reset values: `lcd_en`=0, `lcd_rs`=0, `lcd_rw`=0, `lcd_data`=0x00, `in_ready`=1, FIFO empty.
- `busy` after reset: 1 with init compiled in, 0 without.
- Reset mid-operation: on `reset_n` fall, `lcd_en` drops immediately. The FIFO and the in-flight word are discarded.
- Latency, empty FIFO in IDLE, word pushed at edge N:
  - `lcd_data`/`lcd_rs` valid after edge N+1.
  - `lcd_en` rises at edge N+1+`SETUP_CYC`.
  - `lcd_en` falls `EN_CYC` cycles later.
- Per-word occupancy: `SETUP_CYC`+`EN_CYC`+`HOLD_CYC`+wait cycles.
- Back-to-back words: no idle cycle is inserted between the WAIT of one word and the SETUP of the next.
- Full boundary: `in_ready` returns to 1 the cycle after the pop that frees an entry.

## Configuration
- Macro: `LCD_INIT_SEQ_EN`.
- Defined:
  - After reset, the FSM enters PWRUP for `POWERUP_CYC` cycles.
  - It then issues the fixed commands 0x38, 0x38, 0x38, 0x0C, 0x01, 0x06 with full SETUP/PULSE/HOLD/WAIT timing. 0x01 uses the long wait.
  - Queued words start only after the sequence completes.
  - `in_ready` follows FIFO space during init, so words can queue.
- Undefined: the FSM starts in IDLE and only queued words are issued.

## Test plan
Parameters for the bench: SETUP_CYC=4, EN_CYC=12, HOLD_CYC=2, SHORT_WAIT_CYC=20, LONG_WAIT_CYC=80, POWERUP_CYC=50.
- Single data write, init undefined: push {rs=1, 0x41} at edge N.
  - `lcd_data`=0x41 and `lcd_rs`=1 from N+1.
  - `lcd_en` high for exactly 12 cycles starting at N+5.
  - `busy` falls 38 cycles after N+1.
- Clear command: push {rs=0, 0x01} then {rs=1, 0x42}. The second `lcd_en` rise is exactly 98 cycles after the first. With 0x38 in place of 0x01, the gap is 38.
- FIFO full: hold `in_valid`=1 with 6 distinct words.
  - `in_ready` falls after 5 accepts (4 entries, since one word is already popped).
  - All 5 accepted words appear on `lcd_data` in order; the sixth is never issued.
- Reset mid-pulse: assert `reset_n`=0 while `lcd_en`=1.
  - `lcd_en`=0 with no clock edge.
  - After release: FIFO empty, all outputs at reset values.
- Init enabled, `LCD_INIT_SEQ_EN` defined: no `lcd_en` activity for 50 cycles after reset release.
  - Then six strobes carrying 0x38, 0x38, 0x38, 0x0C, 0x01, 0x06.
  - A word pushed during PWRUP is the seventh strobe.
